// File: rtl/fetch_pkg.sv
// Shared types and constants for the MIPS-32 IF stage.
package fetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  // sll $0,$0,0 encodes as all zeros and is used as the pipeline bubble.
  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc4;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: synchronous active-low reset, squash, load and hold.
module if_id_reg #(
  parameter logic [31:0] BUBBLE = fetch_pkg::NOP_WORD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             squash,
  input  fetch_pkg::if_id_t d,
  output fetch_pkg::if_id_t q
);

  import fetch_pkg::*;

  // Squash outranks load so a redirect always leaves a bubble behind it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q.instr <= BUBBLE;
      q.pc4   <= '0;
      q.valid <= 1'b0;
    end else if (squash) begin
      q.instr <= BUBBLE;
      q.pc4   <= '0;
      q.valid <= 1'b0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS-32 instruction fetch stage: PC, fault detection and IF/ID register.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 512,
  parameter logic [31:0] NOP_WORD   = fetch_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        fetch_fault,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
);

  import fetch_pkg::*;

  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);
  localparam logic [31:0] PC_STEP    = 32'(INSTR_BYTES);

  logic [31:0] pc_plus4;
  logic        in_range;
  logic        advance;
  if_id_t      if_id_d;
  if_id_t      if_id_q;

  assign pc_plus4 = pc + PC_STEP;
  assign in_range = (pc < IMEM_LIMIT);
  assign advance  = !redirect && !stall;

  // An out-of-range fetch still occupies a slot, but as a bubble.
  always_comb begin
    if_id_d.instr = NOP_WORD;
    if_id_d.pc4   = '0;
    if_id_d.valid = 1'b0;
    if (in_range) begin
      if_id_d.instr = instruction;
      if_id_d.pc4   = pc_plus4;
      if_id_d.valid = 1'b1;
    end
  end

  // Redirect beats stall; the target is forced word-aligned and misalignment faults.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc          <= RESET_PC;
      fetch_fault <= 1'b0;
    end else if (redirect) begin
      pc          <= {redirect_pc[31:2], 2'b00};
      fetch_fault <= |redirect_pc[1:0];
    end else if (stall) begin
      fetch_fault <= 1'b0;
    end else begin
      pc          <= pc_plus4;
      fetch_fault <= !in_range;
    end
  end

  if_id_reg #(
    .BUBBLE (NOP_WORD)
  ) u_if_id_reg (
    .clk    (clk),
    .rst    (rst),
    .load   (!stall),
    .squash (redirect),
    .d      (if_id_d),
    .q      (if_id_q)
  );

  assign if_id_instr = if_id_q.instr;
  assign if_id_pc4   = if_id_q.pc4;
  assign if_id_valid = if_id_q.valid;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (advance && in_range) fetch_cnt <= fetch_cnt + 32'd1;
      if (stall && !redirect)  stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt;
  assign perf_stall_cnt = stall_cnt;
`else
  logic unused_advance;
  assign unused_advance = advance;
  assign perf_fetch_cnt = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 5-stage MIPS-32 pipeline. Owns the program counter and the IF/ID pipeline register.
- Drives the byte address to the combinational, byte-addressed, big-endian instruction memory and captures the returned 32-bit word.
- Supports hazard-unit stalls and branch/jump redirects, which squash the younger fetched instruction.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_BYTES, 512, instruction memory size in bytes; fetches at or beyond this address are faults.
- NOP_WORD, 32'h0000_0000, bubble instruction (sll $0,$0,0) injected on squash or fault.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-low (asserted when 0, sampled on rising clk)
- stall  in  1  from hazard unit; hold PC and IF/ID
- redirect  in  1  branch taken or jump resolved; load redirect_pc
- redirect_pc  in  32  target byte address
- instruction  in  32  word returned by instruction memory for pc (same cycle)
- pc  out  32  current fetch address to instruction memory
- if_id_instr  out  32  registered instruction to ID
- if_id_pc4  out  32  registered PC+4 of that instruction
- if_id_valid  out  1  1 = if_id_instr is a real fetched instruction
- fetch_fault  out  1  registered 1-cycle pulse: out-of-range fetch or misaligned redirect
- perf_fetch_cnt  out  32  see Optional Feature
- perf_stall_cnt  out  32  see Optional Feature

Behaviour:
- Reset (rst==0 at posedge):
  - pc=RESET_PC
  - if_id_instr=NOP_WORD, if_id_pc4=0, if_id_valid=0
  - fetch_fault=0, perf counters=0
  - Reset overrides everything, including mid-stall or mid-redirect.
- Memory read is combinational, so the fetch latency is 0 cycles and the IF/ID output is 1 cycle after pc.
- Per-cycle priority: reset > redirect > stall > normal.
- Normal:
  - pc <= pc+4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
  - if_id_instr <= instruction, if_id_pc4 <= pc+4, if_id_valid <= 1.
- Stall (redirect==0):
  - pc and all IF/ID outputs hold their values.
  - fetch_fault is driven to 0.
- Redirect (regardless of stall):
  - pc <= {redirect_pc[31:2],2'b00}.
  - IF/ID squashed: if_id_instr <= NOP_WORD, if_id_valid <= 0, if_id_pc4 <= 0.
  - If redirect_pc[1:0]!=0, fetch_fault <= 1 for one cycle.
- Out-of-range fetch (pc >= IMEM_BYTES, not stalled, no redirect):
  - pc still advances by 4.
  - IF/ID loads NOP_WORD with valid=0, and fetch_fault <= 1.
  - The instruction input is ignored.
- pc[1:0] is always 2'b00 after reset.
- fetch_fault is 0 in any cycle whose edge did not signal a fault.
- Back-to-back redirects: each is honoured and the last one wins. The IF/ID register stays invalid throughout.
- Stall deasserting on the same edge a redirect arrives is covered by the redirect rule.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - perf_fetch_cnt increments on every edge where if_id_valid is loaded with 1.
  - perf_stall_cnt increments on every edge with stall==1 and redirect==0.
  - Both counters wrap at 2^32 and are cleared by reset.
- Undefined: both ports are tied to 32'h0 and no counter flops exist. The port list is unchanged.

Decomposition:
- Package fetch_pkg: XLEN=32, INSTR_BYTES=4, NOP_WORD constant, and the typedef if_id_t {instr[31:0], pc4[31:0], valid}.
- One sub-module, if_id_reg: the pipeline register with load/hold/squash controls and synchronous active-low reset.
- PC logic and fault detection stay in fetch_stage.

Test Plan:
- Reset, then free-run with word 0x24010001 at address 0 and 0x24020005 at address 4 → cycle 1: pc=0x4, if_id_instr=0x24010001, if_id_pc4=0x4, valid=1; cycle 2: pc=0x8, if_id_instr=0x24020005.
- stall=1 for 3 cycles at pc=0x10 → pc stays 0x10, IF/ID unchanged, perf_stall_cnt=3 (macro on); after release, pc=0x14 one cycle later.
- redirect=1 with redirect_pc=0x40 while stall=1 → next cycle: pc=0x40, valid=0, if_id_instr=0; following cycle: valid=1 with word@0x40.
- redirect_pc=0x43 → pc=0x40, fetch_fault pulses for exactly 1 cycle.
- Run sequentially to pc=0x200 (IMEM_BYTES=512) → if_id_valid=0, fetch_fault=1 each cycle, pc=0x204.
- Assert rst=0 mid-stall at pc=0x28 → on the next edge, pc=0, valid=0, counters=0; rst deasserted behaves as normal fetch from 0.
